// File: rtl/arbiter_rr_nch.sv
// N-channel round-robin arbiter merging slave pixel streams into the processing FIFO.
// Bursts stay locked to one channel until last, MAX_BURST beats, or the channel goes idle.
module arbiter_rr_nch #(
    parameter int DW        = 32,
    parameter int N_SLV     = 2,
    parameter int PV_W      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SLV-1:0]           slv_valid,
    input  logic [N_SLV-1:0]           slv_last,
    input  logic [2*N_SLV-1:0]         slv_mode,
    input  logic [DW*N_SLV-1:0]        slv_data,
    input  logic [PV_W*N_SLV-1:0]      slv_proc_val,
    output logic [N_SLV-1:0]           slv_ready,
    input  logic                       fifo_afull,
    input  logic                       mstr_cmplt,
    output logic                       fifo_wr_en,
    output logic [DW-1:0]              fifo_data,
    output logic [1:0]                 fifo_mode,
    output logic [PV_W-1:0]            fifo_proc_val,
    output logic [$clog2(N_SLV)-1:0]   grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(N_SLV);
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    beat_cnt;
    logic [1:0]       mode_lat;

    logic [N_SLV-1:0] req;
    logic             found;
    logic [IDW-1:0]   pick;
    logic [1:0]       pick_mode;

    logic             g_valid;
    logic             g_last;
    logic [1:0]       g_mode;
    logic [DW-1:0]    g_data;
    logic [PV_W-1:0]  g_pv;
    logic             ready_g;
    logic             accept;
    logic             abort;
    logic             burst_end;

    logic             wr_en_p1;
    logic [DW-1:0]    data_p1;
    logic [1:0]       mode_p1;
    logic [PV_W-1:0]  pv_p1;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_SLV) s = s - N_SLV;
        return IDW'(s);
    endfunction

    always_comb begin
        req = '0;
        for (int i = 0; i < N_SLV; i++) begin
            req[i] = slv_valid[i] & (slv_mode[2*i +: 2] != 2'd0);
        end
    end

    // Lowest offset from rr_ptr wins; scan downward so the nearest request overrides.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (req[wrap_idx(rr_ptr, k)]) begin
                pick  = wrap_idx(rr_ptr, k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_mode = '0;
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_mode    = '0;
        g_data    = '0;
        g_pv      = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (pick == IDW'(i)) pick_mode = slv_mode[2*i +: 2];
            if (grant_id == IDW'(i)) begin
                g_valid = slv_valid[i];
                g_last  = slv_last[i];
                g_mode  = slv_mode[2*i +: 2];
                g_data  = slv_data[i*DW +: DW];
                g_pv    = slv_proc_val[i*PV_W +: PV_W];
            end
        end
    end

    // A channel dropping to mode 0 is not given ready; the burst aborts instead.
    assign abort     = (state == XFER) && (g_mode == 2'd0);
    assign ready_g   = (state == XFER) && !fifo_afull && !abort;
    assign accept    = ready_g && g_valid;
    assign burst_end = abort || (accept && (g_last || beat_cnt == CW'(MAX_BURST - 1)));

    always_comb begin
        slv_ready = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (ready_g && grant_id == IDW'(i)) slv_ready[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found && !mstr_cmplt) state_nxt = GRANT;
            GRANT:   state_nxt = XFER;
            XFER:    if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            mode_lat <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && state_nxt == GRANT) begin
                grant_id <= pick;
                mode_lat <= pick_mode;
            end
            if (state == GRANT)  beat_cnt <= '0;
            else if (accept)     beat_cnt <= beat_cnt + 1'b1;
            if (state == XFER && burst_end) rr_ptr <= wrap_idx(grant_id, 1);
        end
    end

    // p1: registered FIFO write, one cycle after the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_p1 <= 1'b0;
            data_p1  <= '0;
            mode_p1  <= '0;
            pv_p1    <= '0;
        end else begin
            wr_en_p1 <= accept;
            if (accept) begin
                data_p1 <= g_data;
                mode_p1 <= mode_lat;
                pv_p1   <= g_pv;
            end
        end
    end

    assign fifo_wr_en    = wr_en_p1;
    assign fifo_data     = data_p1;
    assign fifo_mode     = mode_p1;
    assign fifo_proc_val = pv_p1;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_arbiter_rr_nch.sv
// Directed bench for arbiter_rr_nch (4 channels, MAX_BURST=4): rotation, burst limit,
// back-pressure, master-complete gating and mid-burst reset against hand-written write orders.
module tb_arbiter_rr_nch;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int PV_W = 8;
    localparam int MAXB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      slv_valid;
    logic [N-1:0]      slv_last;
    logic [2*N-1:0]    slv_mode;
    logic [DW*N-1:0]   slv_data;
    logic [PV_W*N-1:0] slv_proc_val;
    logic [N-1:0]      slv_ready;
    logic              fifo_afull;
    logic              mstr_cmplt;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data;
    logic [1:0]        fifo_mode;
    logic [PV_W-1:0]   fifo_proc_val;
    logic [1:0]        grant_id;
    logic              busy;

    always #5 clk = ~clk;

    arbiter_rr_nch #(.DW(DW), .N_SLV(N), .PV_W(PV_W), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .slv_valid(slv_valid), .slv_last(slv_last), .slv_mode(slv_mode),
        .slv_data(slv_data), .slv_proc_val(slv_proc_val), .slv_ready(slv_ready),
        .fifo_afull(fifo_afull), .mstr_cmplt(mstr_cmplt),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .fifo_mode(fifo_mode),
        .fifo_proc_val(fifo_proc_val), .grant_id(grant_id), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk_data(input int c, input int k);
        return {c[7:0], 8'h5A, k[15:0]};
    endfunction

    function automatic logic [7:0] mk_pv(input int c, input int k);
        return 8'(c * 16 + k);
    endfunction

    function automatic logic [1:0] ch_mode(input int c);
        return 2'(c % 3 + 1);
    endfunction

    // Per-channel beat sources: beat k of channel c carries mk_data(c,k)
    int src_len[N];
    int src_rd[N];
    int src_le[N];

    logic [31:0] wlog[64];
    int          wcnt;

    // Expected write orders (channel, beat index)
    int t2c[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int t2i[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int t3c[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 0, 0};
    int t3i[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int t4c[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int t4i[12] = '{0, 1, 2, 3, 0, 1, 4, 5, 6, 7, 8, 9};
    int t5c[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int t5i[12] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0};
    int t6c[12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    int t6i[12] = '{0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0};

    task automatic clear_src();
        for (int c = 0; c < N; c++) begin
            src_len[c] = 0;
            src_rd[c]  = 0;
            src_le[c]  = 0;
        end
    endtask

    task automatic load(input int c, input int n, input int last_every);
        src_rd[c]  = 0;
        src_le[c]  = last_every;
        src_len[c] = n;
    endtask

    task automatic drive_src();
        for (int c = 0; c < N; c++) begin
            if (src_rd[c] < src_len[c]) begin
                slv_valid[c] = 1'b1;
                slv_last[c]  = (src_le[c] != 0) && (((src_rd[c] + 1) % src_le[c]) == 0);
                slv_data[c*DW +: DW]         = mk_data(c, src_rd[c]);
                slv_proc_val[c*PV_W +: PV_W] = mk_pv(c, src_rd[c]);
            end else begin
                slv_valid[c] = 1'b0;
                slv_last[c]  = 1'b0;
                slv_data[c*DW +: DW]         = '0;
                slv_proc_val[c*PV_W +: PV_W] = '0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fifo_afull = 1'b0;
        mstr_cmplt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_src();
        wcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_wcnt(input int n, input int budget, input string tag);
        int cyc;
        cyc = 0;
        while (wcnt < n && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(tag, 32'(wcnt), 32'(n));
    endtask

    task automatic chk_seq(input string tag, input int n, input int ec[12], input int ei[12]);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_beat%0d", tag, i), wlog[i], mk_data(ec[i], ei[i]));
        end
    endtask

    // Slave side: pop a beat once it was accepted at the preceding edge
    initial begin : src_proc
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = slv_valid & slv_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < N; c++) if (acc[c]) src_rd[c]++;
            drive_src();
        end
    end

    // Every accepted beat must appear on the FIFO port exactly one cycle later
    initial begin : mon_proc
        logic         pend;
        logic         ew;
        logic [31:0]  pd;
        logic [7:0]   ppv;
        logic [1:0]   pm;
        int           pc;
        logic [N-1:0] acc;
        pend = 1'b0;
        pd   = '0;
        ppv  = '0;
        pm   = '0;
        pc   = 0;
        forever begin
            @(negedge clk);
            ew = rst_n & pend;
            if (ew || fifo_wr_en) begin
                chk("wr_en", 32'(fifo_wr_en), 32'(ew));
                if (ew) begin
                    chk("wr_data", fifo_data, pd);
                    chk("wr_pv", 32'(fifo_proc_val), 32'(ppv));
                    chk("wr_mode", 32'(fifo_mode), 32'(pm));
                    chk("wr_gid", 32'(grant_id), 32'(pc));
                end
            end
            if (slv_ready != '0) chk("ready_onehot", 32'($countones(slv_ready)), 32'd1);
            if (fifo_wr_en && wcnt < 64) begin
                wlog[wcnt] = fifo_data;
                wcnt++;
            end
            acc  = slv_valid & slv_ready;
            pend = (acc != '0) && rst_n;
            for (int c = 0; c < N; c++) begin
                if (acc[c]) begin
                    pd  = slv_data[c*DW +: DW];
                    ppv = slv_proc_val[c*PV_W +: PV_W];
                    pm  = ch_mode(c);
                    pc  = c;
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b1;
        fifo_afull   = 1'b0;
        mstr_cmplt   = 1'b0;
        slv_valid    = '0;
        slv_last     = '0;
        slv_data     = '0;
        slv_proc_val = '0;
        for (int c = 0; c < N; c++) slv_mode[2*c +: 2] = ch_mode(c);
        clear_src();
        wcnt = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(slv_ready), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_data", fifo_data, 32'd0);
        chk("rst_mode", 32'(fifo_mode), 32'd0);

        // Reset in the middle of a channel-2 burst
        do_reset();
        load(2, 4, 4);
        wait_wcnt(1, 30, "t1_first_wr");
        chk("t1_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_ready", 32'(slv_ready), 32'd0);
        chk("t1_gid", 32'(grant_id), 32'd0);
        chk("t1_data", fifo_data, 32'd0);
        chk("t1_pv", 32'(fifo_proc_val), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_no_wr", 32'(wcnt), 32'd1);

        // Two channels, 3-beat bursts, alternating grants
        do_reset();
        load(0, 6, 3);
        load(1, 6, 3);
        wait_wcnt(12, 100, "t2_count");
        chk_seq("t2", 12, t2c, t2i);

        // All four channels with single-beat bursts: grant order wraps 0,1,2,3,0
        do_reset();
        for (int c = 0; c < N; c++) load(c, 2, 1);
        wait_wcnt(8, 80, "t3_count");
        chk_seq("t3", 8, t3c, t3i);

        // Channel 0 streams 10 beats with no last: forced rotation every 4 beats
        do_reset();
        load(0, 10, 0);
        load(1, 2, 2);
        wait_wcnt(12, 100, "t4_count");
        chk_seq("t4", 12, t4c, t4i);
        chk("t4_locked", 32'(busy), 32'd1);

        // FIFO almost-full during beat 2 for 5 cycles
        do_reset();
        load(0, 5, 5);
        wait_wcnt(1, 30, "t5_first_wr");
        fifo_afull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t5_ready_%0d", i), 32'(slv_ready), 32'd0);
            chk($sformatf("t5_busy_%0d", i), 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("t5_inflight", 32'(wcnt), 32'd2);
        fifo_afull = 1'b0;
        wait_wcnt(5, 40, "t5_count");
        chk_seq("t5", 5, t5c, t5i);

        // Master complete mid-burst: burst finishes, no new grant while it is high
        do_reset();
        load(0, 4, 4);
        load(1, 2, 2);
        wait_wcnt(1, 30, "t6_first_wr");
        mstr_cmplt = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_done_cnt", 32'(wcnt), 32'd4);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ready", 32'(slv_ready), 32'd0);
        chk("t6_gid_hold", 32'(grant_id), 32'd0);
        chk("t6_req_pending", 32'(slv_valid[1]), 32'd1);
        mstr_cmplt = 1'b0;
        wait_wcnt(6, 40, "t6_count");
        chk_seq("t6", 6, t6c, t6i);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
